vid_bus_dma: RTL and testbench

Bus-master DMA engine that drives the video block's CPU-side port (address/write/data/read-select) to bulk-load or dump palette RAM, sprite RAM, VRAM, collision RAM and scroll registers. It sits between a host byte stream (loader / save-state path) and the video CPU port. It arbitrates with the Z80 through BUSRQ/BUSAK and issues byte writes or registered-latency reads at the CPU clock.

---
 rtl/vid_dma_pkg.sv | 25 ++
 rtl/vid_bus_dma.sv | 178 +++++++++++++++++
 tb/tb_vid_bus_dma.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_dma_pkg.sv
// Shared constants for vid_bus_dma: FSM state encoding, transfer direction,
// the unmapped-read byte and the video-port base addresses used by benches.
package vid_dma_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_REQ     = 4'd1;
    localparam logic [3:0] S_WAIT_D  = 4'd2;
    localparam logic [3:0] S_WRITE   = 4'd3;
    localparam logic [3:0] S_RD_ADDR = 4'd4;
    localparam logic [3:0] S_RD_CAP  = 4'd5;
    localparam logic [3:0] S_PUSH    = 4'd6;
    localparam logic [3:0] S_GAPW    = 4'd7;
    localparam logic [3:0] S_REL     = 4'd8;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    localparam logic [7:0] UNMAPPED_RD = 8'hFF;

    localparam logic [15:0] SPRITE_BASE  = 16'hD000;
    localparam logic [15:0] PALETTE_BASE = 16'hD800;
    localparam logic [15:0] VRAM0_BASE   = 16'hE000;
    localparam logic [15:0] VRAM1_BASE   = 16'hE800;

endpackage

// File: rtl/vid_bus_dma.sv
// Bus-master DMA between a host byte stream and the video CPU-side port.
// Read direction is built only when VID_BUS_DMA_READBACK_EN is defined.
module vid_bus_dma
    import vid_dma_pkg::*;
#(
    parameter int LEN_W = 12,
    parameter int GAP   = 0
) (
    input  logic             cpu_cl,
    input  logic             RESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [15:0]      cmd_base,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [7:0]       din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       dout,
    output logic             busrq,
    input  logic             busak,
    output logic [15:0]      m_ad,
    output logic             m_wr,
    output logic [7:0]       m_dw,
    input  logic             m_rd,
    input  logic [7:0]       m_dr,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

    logic [3:0]       state;
    logic             alive;
    logic [1:0]       gap_cnt;
    logic [15:0]      addr;
    logic [15:0]      ad_hold;
    logic [LEN_W-1:0] len_cnt;
    logic             accept;
    logic             access;
    logic             step;
    logic             last;
    logic [3:0]       resume;
    logic [3:0]       after_byte;

    assign cmd_ready = alive && (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busrq     = (state != S_IDLE) && (state != S_REL);
    assign din_ready = (state == S_WAIT_D) && busak;
    assign m_wr      = (state == S_WRITE) && busak;
    assign last      = (len_cnt == LEN_W'(1));

    // The port only shows a fresh address while a bus cycle is actually issued.
    assign access = busak && ((state == S_WRITE) || (state == S_RD_ADDR));
    assign m_ad   = access ? addr : ad_hold;

`ifdef VID_BUS_DMA_READBACK_EN
    logic dir;
    logic rd_ok;

    assign resume     = (dir == DIR_RD) ? S_RD_ADDR : S_WAIT_D;
    assign step       = ((state == S_WRITE) && busak) || ((state == S_PUSH) && dout_ready);
    assign dout_valid = (state == S_PUSH);

    always_ff @(posedge cpu_cl) begin
        if (accept)
            dir <= cmd_dir;
        if ((state == S_RD_ADDR) && busak)
            rd_ok <= m_rd;
    end
`else
    logic unused_rd;

    assign resume     = S_WAIT_D;
    assign step       = (state == S_WRITE) && busak;
    assign dout_valid = 1'b0;
    assign unused_rd  = ^{m_rd, m_dr, dout_ready};
`endif

    assign after_byte = last ? S_REL : ((GAP > 0) ? S_GAPW : resume);

    always_ff @(posedge cpu_cl) begin
        if (accept) begin
            addr    <= cmd_base;
            len_cnt <= cmd_len;
        end else if (step) begin
            addr    <= addr + 16'd1;
            len_cnt <= len_cnt - LEN_W'(1);
        end
    end

    always_ff @(posedge cpu_cl or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            alive   <= 1'b0;
            gap_cnt <= 2'd0;
            ad_hold <= 16'h0000;
            m_dw    <= 8'h00;
            dout    <= 8'h00;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            alive <= 1'b1;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        err <= 1'b0;
                        if (cmd_len == '0)
                            done <= 1'b1;
`ifdef VID_BUS_DMA_READBACK_EN
                        else
                            state <= S_REQ;
`else
                        else if (cmd_dir == DIR_RD) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else
                            state <= S_REQ;
`endif
                    end
                end
                S_REQ: begin
                    if (busak)
                        state <= resume;
                end
                S_WAIT_D: begin
                    if (busak && din_valid) begin
                        m_dw  <= din;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (busak) begin
                        ad_hold <= addr;
                        gap_cnt <= GAP_LAST;
                        state   <= after_byte;
                    end
                end
`ifdef VID_BUS_DMA_READBACK_EN
                S_RD_ADDR: begin
                    if (busak) begin
                        ad_hold <= addr;
                        state   <= S_RD_CAP;
                    end
                end
                S_RD_CAP: begin
                    // m_dr is registered in the video block, so it lags m_ad by one cycle.
                    dout <= rd_ok ? m_dr : UNMAPPED_RD;
                    if (!rd_ok)
                        err <= 1'b1;
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (dout_ready) begin
                        gap_cnt <= GAP_LAST;
                        state   <= after_byte;
                    end
                end
`endif
                S_GAPW: begin
                    if (gap_cnt == 2'd0)
                        state <= resume;
                    else
                        gap_cnt <= gap_cnt - 2'd1;
                end
                S_REL: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_bus_dma.sv
// Directed bench for vid_bus_dma: write bursts, wraparound, bus loss, reset,
// no-op and read-direction behaviour for either VID_BUS_DMA_READBACK_EN build.
module tb_vid_bus_dma;
    import vid_dma_pkg::*;

    logic        cpu_cl;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_base;
    logic [11:0] cmd_len;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  din;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout;
    logic        busrq;
    logic        busak;
    logic [15:0] m_ad;
    logic        m_wr;
    logic [7:0]  m_dw;
    logic        m_rd;
    logic [7:0]  m_dr;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int bad_wr = 0;
    int bad_dr = 0;
    logic busrq_seen = 1'b0;
    int wr_ad[$];
    int wr_dw[$];
    int wr_cyc[$];
    int rq[$];
    logic [7:0] wq[$];

    vid_bus_dma #(.LEN_W(12), .GAP(0)) dut (
        .cpu_cl(cpu_cl), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .busrq(busrq), .busak(busak),
        .m_ad(m_ad), .m_wr(m_wr), .m_dw(m_dw), .m_rd(m_rd), .m_dr(m_dr),
        .done(done), .err(err)
    );

    initial begin
        cpu_cl = 1'b0;
        forever #5 cpu_cl = ~cpu_cl;
    end

    initial begin
        forever begin
            @(posedge cpu_cl);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge cpu_cl);
            if (m_wr) begin
                wr_ad.push_back(int'(m_ad));
                wr_dw.push_back(int'(m_dw));
                wr_cyc.push_back(cyc);
            end
            if (m_wr && !busak) bad_wr++;
            if (din_ready && !busak) bad_dr++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busrq) busrq_seen = 1'b1;
            if (dout_valid && dout_ready) rq.push_back(int'(dout));
        end
    end

    // Write-data source.
    initial begin
        logic take;
        din_valid = 1'b0;
        din = 8'h00;
        forever begin
            @(negedge cpu_cl);
            take = din_valid && din_ready;
            @(posedge cpu_cl);
            #1;
            if (take && wq.size() > 0) void'(wq.pop_front());
            din_valid = (wq.size() > 0);
            din = (wq.size() > 0) ? wq[0] : 8'h00;
        end
    end

    // Video-port read model: m_rd combinational, m_dr one cycle behind m_ad.
    initial begin
        logic [15:0] ad_s;
        m_rd = 1'b1;
        m_dr = 8'h00;
        forever begin
            @(negedge cpu_cl);
            ad_s = m_ad;
            m_rd = (m_ad[15:12] != 4'hF);
            @(posedge cpu_cl);
            #1;
            m_dr = (ad_s == 16'hE000) ? 8'h5A : (ad_s == 16'hE001) ? 8'hA5 : ad_s[7:0];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge cpu_cl);
        #1;
    endtask

    task automatic clear();
        wr_ad.delete();
        wr_dw.delete();
        wr_cyc.delete();
        rq.delete();
        done_cnt = 0;
        bad_wr = 0;
        bad_dr = 0;
        busrq_seen = 1'b0;
    endtask

    task automatic send(input logic dir, input logic [15:0] base, input logic [11:0] len);
        int k = 0;
        @(negedge cpu_cl);
        while (!cmd_ready && k < 50) begin
            @(negedge cpu_cl);
            k++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_dir = dir;
        cmd_base = base;
        cmd_len = len;
        acc_cyc = cyc;
        @(posedge cpu_cl);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int k = 0;
        @(negedge cpu_cl);
        while (!done && k < n) begin
            @(negedge cpu_cl);
            k++;
        end
        if (!done) chk(tag, 32'd0, 32'd1);
        idle(3);
    endtask

    task automatic wait_wr(input string tag, input int cnt, input int n);
        int k = 0;
        @(negedge cpu_cl);
        while (wr_ad.size() < cnt && k < n) begin
            @(negedge cpu_cl);
            k++;
        end
        if (wr_ad.size() < cnt) chk(tag, 32'(wr_ad.size()), 32'(cnt));
    endtask

    initial begin
        int exp_dw[4];
        int w;
        exp_dw = '{32'h11, 32'h22, 32'h33, 32'h44};
        RESET = 1'b1;
        busak = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = DIR_WR;
        cmd_base = 16'h0000;
        cmd_len = 12'd0;
        dout_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge cpu_cl);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busrq", 32'(busrq), 32'd0);
        chk("rst_m_wr", 32'(m_wr), 32'd0);
        chk("rst_m_ad", 32'(m_ad), 32'h0000);
        chk("rst_m_dw", 32'(m_dw), 32'h00);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge cpu_cl);
        #1 RESET = 1'b0;
        idle(2);
        @(negedge cpu_cl);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        idle(1);

        // Four-byte write to palette RAM.
        clear();
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
        send(DIR_WR, PALETTE_BASE, 12'd4);
        @(negedge cpu_cl);
        chk("wr_busrq_lat", 32'(busrq), 32'd1);
        wait_done("wr_done_timeout", 60);
        chk("wr_count", 32'(wr_ad.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_ad%0d", i), 32'(qat(wr_ad, i)), 32'h0000D800 + 32'(i));
            chk($sformatf("wr_dw%0d", i), 32'(qat(wr_dw, i)), 32'(exp_dw[i]));
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("wr_space%0d", i), 32'(qat(wr_cyc, i) - qat(wr_cyc, i - 1)), 32'd2);
        chk("wr_first_lat", 32'(qat(wr_cyc, 0) - acc_cyc), 32'd3);
        chk("wr_done_lat", 32'(done_cyc - qat(wr_cyc, 3)), 32'd2);
        chk("wr_done_cnt", 32'(done_cnt), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_busrq_rel", 32'(busrq), 32'd0);

        // Address wraps from FFFF to 0000.
        clear();
        wq.push_back(8'h5C); wq.push_back(8'hC5);
        send(DIR_WR, 16'hFFFF, 12'd2);
        wait_done("wrap_done_timeout", 40);
        chk("wrap_ad0", 32'(qat(wr_ad, 0)), 32'h0000FFFF);
        chk("wrap_ad1", 32'(qat(wr_ad, 1)), 32'h00000000);
        chk("wrap_dw1", 32'(qat(wr_dw, 1)), 32'hC5);
        chk("wrap_err", 32'(err), 32'd0);

        // Bus taken back for five cycles after the first of three writes.
        clear();
        wq.push_back(8'hA1); wq.push_back(8'hA2); wq.push_back(8'hA3);
        send(DIR_WR, SPRITE_BASE, 12'd3);
        wait_wr("busak_first_timeout", 1, 40);
        w = qat(wr_cyc, 0);
        @(posedge cpu_cl);
        #1 busak = 1'b0;
        @(negedge cpu_cl);
        chk("busak_gap_busrq", 32'(busrq), 32'd1);
        chk("busak_gap_din_ready", 32'(din_ready), 32'd0);
        repeat (5) @(posedge cpu_cl);
        #1 busak = 1'b1;
        wait_done("busak_done_timeout", 60);
        chk("busak_wr_count", 32'(wr_ad.size()), 32'd3);
        chk("busak_bad_wr", 32'(bad_wr), 32'd0);
        chk("busak_bad_dr", 32'(bad_dr), 32'd0);
        chk("busak_resume", 32'(qat(wr_cyc, 1) - w), 32'd7);
        chk("busak_ad2", 32'(qat(wr_ad, 2)), 32'h0000D002);
        chk("busak_dw2", 32'(qat(wr_dw, 2)), 32'hA3);
        chk("busak_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the middle of a write command.
        clear();
        wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03); wq.push_back(8'h04);
        send(DIR_WR, VRAM1_BASE, 12'd4);
        wait_wr("rstmid_wr_timeout", 2, 40);
        @(posedge cpu_cl);
        #1 RESET = 1'b1;
        #1;
        chk("rstmid_busrq", 32'(busrq), 32'd0);
        chk("rstmid_m_wr", 32'(m_wr), 32'd0);
        chk("rstmid_m_ad", 32'(m_ad), 32'h0000);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
        idle(3);
        RESET = 1'b0;
        wq.delete();
        idle(4);
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        chk("rstmid_wr_count", 32'(wr_ad.size()), 32'd2);

        // Zero length is a no-op that still completes.
        clear();
        send(DIR_WR, 16'h1234, 12'd0);
        @(negedge cpu_cl);
        chk("len0_done", 32'(done), 32'd1);
        idle(4);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        chk("len0_busrq", 32'(busrq_seen), 32'd0);
        chk("len0_err", 32'(err), 32'd0);

`ifdef VID_BUS_DMA_READBACK_EN
        // Two-byte read with three stalled cycles on the output.
        clear();
        dout_ready = 1'b0;
        send(DIR_RD, VRAM0_BASE, 12'd2);
        begin
            int k = 0;
            @(negedge cpu_cl);
            while (!dout_valid && k < 40) begin
                @(negedge cpu_cl);
                k++;
            end
            chk("rd_valid_lat", 32'(cyc - acc_cyc), 32'd4);
        end
        @(posedge cpu_cl);
        @(negedge cpu_cl);
        chk("rd_stall_valid", 32'(dout_valid), 32'd1);
        chk("rd_stall_dout", 32'(dout), 32'h5A);
        repeat (2) @(posedge cpu_cl);
        #1 dout_ready = 1'b1;
        wait_done("rd_done_timeout", 40);
        chk("rd_count", 32'(rq.size()), 32'd2);
        chk("rd_byte0", 32'(qat(rq, 0)), 32'h5A);
        chk("rd_byte1", 32'(qat(rq, 1)), 32'hA5);
        chk("rd_err", 32'(err), 32'd0);
        chk("rd_done_cnt", 32'(done_cnt), 32'd1);

        // Read of an unmapped address.
        clear();
        send(DIR_RD, 16'hF400, 12'd1);
        wait_done("unmap_done_timeout", 40);
        chk("unmap_byte", 32'(qat(rq, 0)), 32'hFF);
        chk("unmap_err", 32'(err), 32'd1);
`else
        // Read command without readback support.
        clear();
        send(DIR_RD, VRAM0_BASE, 12'd2);
        @(negedge cpu_cl);
        chk("nord_done", 32'(done), 32'd1);
        chk("nord_err", 32'(err), 32'd1);
        idle(4);
        chk("nord_busrq", 32'(busrq_seen), 32'd0);
        chk("nord_done_cnt", 32'(done_cnt), 32'd1);
        chk("nord_dout_valid", 32'(dout_valid), 32'd0);
        chk("nord_err_sticky", 32'(err), 32'd1);
`endif

        // The next accepted command clears err.
        clear();
        wq.push_back(8'h77);
        send(DIR_WR, SPRITE_BASE, 12'd1);
        @(negedge cpu_cl);
        chk("err_clear", 32'(err), 32'd0);
        wait_done("clr_done_timeout", 40);
        chk("clr_wr_dw", 32'(qat(wr_dw, 0)), 32'h77);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
